// File: rtl/hwpe_sm_buffer_pkg.sv
// Shared types and constants for the HWPE TCDM decoupling buffer.
// tcdm_req_t describes one queued request at the default widths; the
// buffer itself packs entries in the same {type, add, be, data} order so
// that the struct can be overlaid on a FIFO entry when widths match.
package hwpe_sm_buffer_pkg;

  localparam int unsigned REQ_ADDR_W = 32;
  localparam int unsigned REQ_DATA_W = 32;
  localparam int unsigned REQ_BE_W   = REQ_DATA_W / 8;

  // Controller tcdm_type encoding
  localparam logic TYPE_WRITE = 1'b1;
  localparam logic TYPE_READ  = 1'b0;

  typedef struct packed {
    logic                  req_type;
    logic [REQ_ADDR_W-1:0] add;
    logic [REQ_BE_W-1:0]   be;
    logic [REQ_DATA_W-1:0] data;
  } tcdm_req_t;

endpackage

// File: rtl/hwpe_sm_fifo.sv
// Generic synchronous FIFO with a combinational head output.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear_i        synchronous flush (pointers return to 0 next cycle)
//   push_i/data_i  write side; ignored while full or clearing
//   pop_i          read side; ignored while empty or clearing
//   data_o         current head entry (undefined while empty)
//   full_o/empty_o occupancy status
module hwpe_sm_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  assign do_push = push_i & ~full_o  & ~clear_i;
  assign do_pop  = pop_i  & ~empty_o & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_q[IDX_W-1:0] == IDX_W'(gi))) begin
        mem_q[gi] <= data_i;
      end
    end
  end

  assign data_o = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: rtl/hwpe_sm_tcdm_buffer.sv
// Decoupling buffer between an HWPE controller TCDM master port and the
// cluster log-interconnect. Requests are queued in a FIFO (no bypass),
// reads in flight are capped at MAX_OUTSTANDING, read responses are
// forwarded through one register stage in order.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clear_i                  flush queued requests and the error flag
//   in_*                     controller side (req/gnt/add/type/be/data, r_data/r_valid)
//   out_*                    interconnect side (req/gnt/add/type/be/data, r_data/r_valid)
//   idle_o                   nothing queued and no reads awaiting a response
//   err_o                    sticky: a response arrived with no read outstanding
module hwpe_sm_tcdm_buffer
  import hwpe_sm_buffer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  in_req_i,
  output logic                  in_gnt_o,
  input  logic [ADDR_WIDTH-1:0] in_add_i,
  input  logic                  in_type_i,
  input  logic [BE_WIDTH-1:0]   in_be_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic [DATA_WIDTH-1:0] in_r_data_o,
  output logic                  in_r_valid_o,
  output logic                  out_req_o,
  input  logic                  out_gnt_i,
  output logic [ADDR_WIDTH-1:0] out_add_o,
  output logic                  out_type_o,
  output logic [BE_WIDTH-1:0]   out_be_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic [DATA_WIDTH-1:0] out_r_data_i,
  input  logic                  out_r_valid_i,
  output logic                  idle_o,
  output logic                  err_o
);

  localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + BE_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [ENTRY_W-1:0]    push_entry, head_entry;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, head_is_write, rd_issue, rd_slot_free;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  err_q, err_d;
  logic                  r_valid_q;
  logic [DATA_WIDTH-1:0] r_data_q;

  assign push_entry = {in_type_i, in_add_i, in_be_i, in_data_i};
  assign {out_type_o, out_add_o, out_be_o, out_data_o} = head_entry;

  assign in_gnt_o = ~fifo_full & ~clear_i;
  assign push     = in_req_i & in_gnt_o;

  // Writes never wait on the read cap; reads stall at the head until a
  // response frees a slot, which also blocks younger writes (in order).
  assign head_is_write = (out_type_o == TYPE_WRITE);
  assign rd_slot_free  = (rd_cnt_q < CNT_MAX);
  assign out_req_o     = ~fifo_empty & ~clear_i & (head_is_write | rd_slot_free);
  assign pop           = out_req_o & out_gnt_i;
  assign rd_issue      = pop & ~head_is_write;

  hwpe_sm_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outstanding-read counter and error flag. clear_i leaves the counter
  // alone so reads already in flight are still accounted for.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    err_d    = err_q;
    if (out_r_valid_i && (rd_cnt_q == '0)) begin
      // Spurious response: counter saturates at zero.
      err_d = 1'b1;
    end else if (rd_issue && !out_r_valid_i) begin
      rd_cnt_d = rd_cnt_q + CNT_ONE;
    end else if (!rd_issue && out_r_valid_i) begin
      rd_cnt_d = rd_cnt_q - CNT_ONE;
    end
    if (clear_i) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q  <= '0;
      err_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
      r_valid_q <= out_r_valid_i;
      if (out_r_valid_i) r_data_q <= out_r_data_i;
    end
  end

  assign in_r_valid_o = r_valid_q;
  assign in_r_data_o  = r_data_q;
  assign idle_o       = fifo_empty & (rd_cnt_q == '0);
  assign err_o        = err_q;

endmodule

// File: tb/tb_hwpe_sm_tcdm_buffer.sv
// Directed bench for hwpe_sm_tcdm_buffer. Accepted requests are queued as
// expected issues and checked when the interconnect side grants them;
// driven responses are queued and checked when forwarded to the controller.
module tb_hwpe_sm_tcdm_buffer;
  import hwpe_sm_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        in_req_i = 1'b0;
  logic        in_gnt_o;
  logic [31:0] in_add_i = '0;
  logic        in_type_i = 1'b0;
  logic [3:0]  in_be_i = '0;
  logic [31:0] in_data_i = '0;
  logic [31:0] in_r_data_o;
  logic        in_r_valid_o;
  logic        out_req_o;
  logic        out_gnt_i = 1'b0;
  logic [31:0] out_add_o;
  logic        out_type_o;
  logic [3:0]  out_be_o;
  logic [31:0] out_data_o;
  logic [31:0] out_r_data_i = '0;
  logic        out_r_valid_i = 1'b0;
  logic        idle_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;
  tcdm_req_t   outq[$];
  logic [31:0] respq[$];

  always #5 clk = ~clk;

  hwpe_sm_tcdm_buffer #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .BE_WIDTH        (4),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear_i),
    .in_req_i      (in_req_i),
    .in_gnt_o      (in_gnt_o),
    .in_add_i      (in_add_i),
    .in_type_i     (in_type_i),
    .in_be_i       (in_be_i),
    .in_data_i     (in_data_i),
    .in_r_data_o   (in_r_data_o),
    .in_r_valid_o  (in_r_valid_o),
    .out_req_o     (out_req_o),
    .out_gnt_i     (out_gnt_i),
    .out_add_o     (out_add_o),
    .out_type_o    (out_type_o),
    .out_be_o      (out_be_o),
    .out_data_o    (out_data_o),
    .out_r_data_i  (out_r_data_i),
    .out_r_valid_i (out_r_valid_i),
    .idle_o        (idle_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic req, input logic typ, input logic [31:0] add,
                     input logic [31:0] data);
    in_req_i  = req;
    in_type_i = typ;
    in_add_i  = add;
    in_be_i   = 4'hF;
    in_data_i = data;
  endtask

  // Sample handshakes just after the inputs settle, then move to the next
  // falling edge where the caller drives the following cycle.
  task automatic tick();
    tcdm_req_t   obs_e, exp_e;
    logic [31:0] exp_d;
    #1;
    if (in_r_valid_o) begin
      if (respq.size() == 0) begin
        chk("resp_unexpected", 128'(in_r_valid_o), 128'(0));
      end else begin
        exp_d = respq.pop_front();
        $display("resp   data=%h", in_r_data_o);
        chk("resp_data", 128'(in_r_data_o), 128'(exp_d));
      end
    end
    if (out_req_o && out_gnt_i) begin
      obs_e = {out_type_o, out_add_o, out_be_o, out_data_o};
      if (outq.size() == 0) begin
        chk("issue_unexpected", 128'(out_req_o), 128'(0));
      end else begin
        exp_e = outq.pop_front();
        $display("issue  type=%0d add=%h be=%h data=%h", out_type_o, out_add_o, out_be_o, out_data_o);
        chk("issue_entry", 128'(obs_e), 128'(exp_e));
      end
    end
    if (in_req_i && in_gnt_o) begin
      outq.push_back({in_type_i, in_add_i, in_be_i, in_data_i});
      $display("accept type=%0d add=%h data=%h", in_type_i, in_add_i, in_data_i);
    end
    if (out_r_valid_i) respq.push_back(out_r_data_i);
    if (clear_i) outq.delete();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_gnt",    128'(in_gnt_o),     128'(1));
    chk("rst_req",    128'(out_req_o),    128'(0));
    chk("rst_rvalid", 128'(in_r_valid_o), 128'(0));
    chk("rst_rdata",  128'(in_r_data_o),  128'(0));
    chk("rst_idle",   128'(idle_o),       128'(1));
    chk("rst_err",    128'(err_o),        128'(0));
    rst = 1'b0;

    // Single read
    drv(1'b1, TYPE_READ, 32'h1000, 32'h0);
    #1;
    chk("t1_gnt", 128'(in_gnt_o), 128'(1));
    chk("t1_no_bypass", 128'(out_req_o), 128'(0));
    tick();
    drv(1'b0, TYPE_READ, 32'h0, 32'h0);
    #1;
    chk("t1_req",  128'(out_req_o),  128'(1));
    chk("t1_add",  128'(out_add_o),  128'(32'h1000));
    chk("t1_type", 128'(out_type_o), 128'(0));
    out_gnt_i = 1'b1;
    tick();
    out_gnt_i = 1'b0;
    #1;
    chk("t1_busy", 128'(idle_o), 128'(0));
    tick();
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'hCAFE_F00D;
    tick();
    out_r_valid_i = 1'b0;
    out_r_data_i  = 32'h0;
    #1;
    chk("t1_rvalid", 128'(in_r_valid_o), 128'(1));
    chk("t1_rdata",  128'(in_r_data_o),  128'(32'hCAFE_F00D));
    chk("t1_idle",   128'(idle_o),       128'(1));
    tick();

    // Fill under stall, then drain
    out_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drv(1'b1, TYPE_WRITE, 32'h2000 + 32'(4 * k), 32'hA0 + 32'(k));
      #1;
      chk("t2_gnt", 128'(in_gnt_o), 128'(1));
      if (k > 0) begin
        chk("t2_hold_req", 128'(out_req_o), 128'(1));
        chk("t2_hold_add", 128'(out_add_o), 128'(32'h2000));
      end
      tick();
    end
    drv(1'b1, TYPE_WRITE, 32'h2010, 32'hA4);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t2_full_gnt", 128'(in_gnt_o),  128'(0));
      chk("t2_full_add", 128'(out_add_o), 128'(32'h2000));
      tick();
    end
    out_gnt_i = 1'b1;
    #1;
    chk("t2_gnt_pop_cycle", 128'(in_gnt_o), 128'(0));
    tick();
    #1;
    chk("t2_gnt_after_pop", 128'(in_gnt_o), 128'(1));
    tick();
    drv(1'b0, TYPE_WRITE, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_drain_req", 128'(out_req_o), 128'(1));
      tick();
    end
    #1;
    chk("t2_empty_req", 128'(out_req_o), 128'(0));
    chk("t2_idle",      128'(idle_o),    128'(1));
    tick();

    // Outstanding-read cap
    out_gnt_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drv(1'b1, TYPE_READ, 32'h3000 + 32'(4 * k), 32'h0);
      #1;
      chk("t3_gnt", 128'(in_gnt_o), 128'(1));
      chk("t3_req", 128'(out_req_o), 128'((k >= 1) && (k <= 4)));
      tick();
    end
    drv(1'b0, TYPE_READ, 32'h0, 32'h0);
    #1;
    chk("t3_capped", 128'(out_req_o), 128'(0));
    tick();
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'h1111_0000;
    #1;
    chk("t3_capped_rv", 128'(out_req_o), 128'(0));
    tick();
    out_r_valid_i = 1'b0;
    #1;
    chk("t3_reissue", 128'(out_req_o), 128'(1));
    tick();
    out_gnt_i = 1'b0;
    #1;
    chk("t3_capped_again", 128'(out_req_o), 128'(0));
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'h1111_0001;
    tick();
    out_r_data_i  = 32'h1111_0002;
    tick();

    // Read issue and response in the same cycle at rd_cnt=2
    out_gnt_i    = 1'b1;
    out_r_data_i = 32'h2222_0000;
    #1;
    chk("t4_req", 128'(out_req_o), 128'(1));
    tick();
    out_gnt_i     = 1'b0;
    out_r_valid_i = 1'b0;
    #1;
    chk("t4_rvalid_pulse", 128'(in_r_valid_o), 128'(1));
    chk("t4_empty_req",    128'(out_req_o),    128'(0));
    chk("t4_busy",         128'(idle_o),       128'(0));
    tick();
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'h2222_0001;
    tick();
    out_r_valid_i = 1'b0;
    #1;
    chk("t4_one_left", 128'(idle_o), 128'(0));
    tick();
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'h2222_0002;
    tick();
    out_r_valid_i = 1'b0;
    #1;
    chk("t4_idle", 128'(idle_o), 128'(1));
    chk("t4_err",  128'(err_o),  128'(0));
    tick();

    // Clear with queued writes and reads in flight
    out_gnt_i = 1'b1;
    drv(1'b1, TYPE_READ, 32'h4000, 32'h0);
    tick();
    drv(1'b1, TYPE_READ, 32'h4004, 32'h0);
    tick();
    drv(1'b1, TYPE_WRITE, 32'h5000, 32'hB0);
    tick();
    out_gnt_i = 1'b0;
    drv(1'b1, TYPE_WRITE, 32'h5004, 32'hB1);
    tick();
    drv(1'b1, TYPE_WRITE, 32'h5008, 32'hB2);
    tick();
    drv(1'b0, TYPE_WRITE, 32'h0, 32'h0);
    clear_i   = 1'b1;
    out_gnt_i = 1'b1;
    #1;
    chk("t5_clr_gnt", 128'(in_gnt_o),  128'(0));
    chk("t5_clr_req", 128'(out_req_o), 128'(0));
    tick();
    clear_i = 1'b0;
    #1;
    chk("t5_empty_req", 128'(out_req_o), 128'(0));
    chk("t5_busy",      128'(idle_o),    128'(0));
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'h3333_0000;
    tick();
    out_r_data_i = 32'h3333_0001;
    tick();
    out_r_valid_i = 1'b0;
    out_gnt_i     = 1'b0;
    #1;
    chk("t5_idle", 128'(idle_o), 128'(1));
    tick();

    // Spurious response
    out_r_valid_i = 1'b1;
    out_r_data_i  = 32'hDEAD_BEEF;
    #1;
    chk("t6_err_before", 128'(err_o), 128'(0));
    tick();
    out_r_valid_i = 1'b0;
    out_r_data_i  = 32'h0;
    #1;
    chk("t6_err_set", 128'(err_o),       128'(1));
    chk("t6_fwd",     128'(in_r_data_o), 128'(32'hDEAD_BEEF));
    chk("t6_idle",    128'(idle_o),      128'(1));
    tick();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t6_err_sticky", 128'(err_o), 128'(1));
      tick();
    end
    clear_i = 1'b1;
    #1;
    chk("t6_err_clr_cycle", 128'(err_o), 128'(1));
    tick();
    clear_i = 1'b0;
    #1;
    chk("t6_err_cleared", 128'(err_o), 128'(0));
    tick();

    chk("issues_drained",    128'(outq.size()),  128'(0));
    chk("responses_drained", 128'(respq.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
